// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width plus operand-select stage types
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int MXN_MAX_IN = 16;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} mxn_state_e;
endpackage

// File: rtl/mxn_skid_if.sv
// mxn_skid_if: producer/consumer handshake bundle of the operand-select stage
interface mxn_skid_if import riscv_pkg::*; #(parameter int N_IN = 4) ();
  localparam int SEL_W = $clog2(N_IN);
  logic [N_IN-1:0][XLEN-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic flush;
  logic sel_err;
  modport master(output in_data, in_sel, in_valid, out_ready, flush,
                 input in_ready, out_data, out_valid, sel_err);
  modport slave(input in_data, in_sel, in_valid, out_ready, flush,
                output in_ready, out_data, out_valid, sel_err);
endinterface

// File: rtl/mxn_skid_mxn.sv
// mxn: combinational N:1 XLEN mux; out-of-range selects yield 0 and raise oor
module mxn import riscv_pkg::*; #(
  parameter int N_IN = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0][XLEN-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  output logic [XLEN-1:0]           y,
  output logic                      oor
);
  always_comb begin
    y = '0;
    oor = int'(sel) >= N_IN;
    for (int i = 0; i < N_IN; i++) y = (sel == SEL_W'(i)) ? d[i] : y;
  end
endmodule

// File: rtl/mxn_skid.sv
// mxn_skid: N:1 operand select with a registered two-entry skid output buffer
module mxn_skid import riscv_pkg::*; #(parameter int N_IN = 4) (
  input logic       clk,
  input logic       rst_n,
  mxn_skid_if.slave bus
);
  mxn_state_e state, nxt;
  logic [XLEN-1:0] main_q, skid_q, main_d, skid_d, cap;
  logic oor, acc, pop, err_q;
  mxn #(.N_IN(N_IN)) u_mxn (.d(bus.in_data), .sel(bus.in_sel), .y(cap), .oor(oor));
  assign bus.in_ready = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_data = main_q;
  assign bus.sel_err = err_q;
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    nxt = state;
    main_d = main_q;
    skid_d = skid_q;
    case (state)
      EMPTY: begin
        nxt = acc ? ONE : EMPTY;
        main_d = acc ? cap : main_q;
      end
      ONE: begin
        nxt = (acc && !pop) ? TWO : (!acc && pop) ? EMPTY : ONE;
        main_d = (acc && pop) ? cap : main_q;
        skid_d = (acc && !pop) ? cap : skid_q;
      end
      default: begin
        nxt = pop ? ONE : TWO;
        main_d = pop ? skid_q : main_q;
      end
    endcase
    nxt = bus.flush ? EMPTY : nxt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      main_q <= main_d;
      skid_q <= skid_d;
      err_q <= bus.flush ? 1'b0 : err_q | (acc && oor);
    end
endmodule

// File: tb/tb_mxn_skid.sv
// tb_mxn_skid: directed checks on N_IN=4/3 plus randomized queue-model runs on N_IN=2/5/16
module tb_mxn_skid;
  import riscv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_r = 1'b0;
  int checks = 0;
  int errors = 0;
  int done = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  mxn_skid_if #(.N_IN(4)) b4();
  mxn_skid_if #(.N_IN(3)) b3();
  mxn_skid #(.N_IN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  mxn_skid #(.N_IN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int NI = g == 0 ? 2 : g == 1 ? 5 : 16;
    localparam int SW = $clog2(NI);
    mxn_skid_if #(.N_IN(NI)) bus();
    mxn_skid #(.N_IN(NI)) dut (.clk(clk), .rst_n(rst_r), .bus(bus.slave));
    logic [31:0] q[$];
    bit err = 1'b0;
    initial begin
      bus.in_data = '0;
      bus.in_sel = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.flush = 1'b0;
      wait (rst_r);
      step();
      repeat (10000) begin
        for (int i = 0; i < NI; i++) bus.in_data[i] = $urandom;
        bus.in_sel = SW'($urandom);
        bus.in_valid = $urandom_range(0, 3) != 0;
        bus.out_ready = $urandom_range(0, 2) != 0;
        bus.flush = $urandom_range(0, 63) == 0;
        step();
      end
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      done++;
    end
    initial forever begin
      @(posedge clk);
      if (rst_r) begin
        automatic bit a = bus.in_valid && q.size() < 2;
        automatic bit p = bus.out_ready && q.size() > 0;
        automatic int s = int'(bus.in_sel);
        automatic logic [31:0] v = 32'h0;
        if (s < NI) v = bus.in_data[s];
        if (bus.flush) begin
          q.delete();
          err = 1'b0;
        end else begin
          if (p) void'(q.pop_front());
          if (a) q.push_back(v);
          if (a && s >= NI) err = 1'b1;
        end
      end
    end
    initial forever begin
      @(negedge clk);
      if (rst_r) begin
        chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("rnd_sel_err", 32'(bus.sel_err), 32'(err));
        if (q.size() > 0) chk("rnd_out_data", bus.out_data, q[0]);
      end
    end
  end

  initial begin
    b4.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    b4.in_sel = '0;
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    b4.flush = 1'b0;
    b3.in_data = {32'hC2, 32'hB1, 32'hA0};
    b3.in_sel = '0;
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    b3.flush = 1'b0;
    #2;
    chk("rst_in_ready", 32'(b4.in_ready), 1);
    chk("rst_out_valid", 32'(b4.out_valid), 0);
    chk("rst_out_data", b4.out_data, 0);
    chk("rst_sel_err", 32'(b4.sel_err), 0);
    #10;
    rst_n = 1'b1;
    rst_r = 1'b1;
    for (int s = 0; s < 4; s++) begin
      b4.in_sel = 2'(s);
      b4.in_valid = 1'b1;
      step();
      chk("stream_data", b4.out_data, 32'h11 * (s + 1));
      chk("stream_ready", 32'(b4.in_ready), 1);
    end
    b4.in_valid = 1'b0;
    step();
    chk("stream_drain", 32'(b4.out_valid), 0);
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd1;
    step();
    chk("stall_first_ready", 32'(b4.in_ready), 1);
    b4.in_sel = 2'd2;
    step();
    chk("stall_two_ready", 32'(b4.in_ready), 0);
    chk("stall_head", b4.out_data, 32'h22);
    b4.in_valid = 1'b0;
    step();
    chk("stall_hold", b4.out_data, 32'h22);
    b4.out_ready = 1'b1;
    step();
    chk("stall_pop1_data", b4.out_data, 32'h33);
    chk("stall_pop1_ready", 32'(b4.in_ready), 1);
    step();
    chk("stall_pop2_empty", 32'(b4.out_valid), 0);
    b3.in_valid = 1'b1;
    b3.in_sel = 2'd3;
    step();
    chk("bad_sel_data", b3.out_data, 0);
    chk("bad_sel_valid", 32'(b3.out_valid), 1);
    chk("bad_sel_err", 32'(b3.sel_err), 1);
    for (int i = 0; i < 10; i++) begin
      b3.in_sel = 2'(i % 3);
      step();
      chk("bad_sel_flow", b3.out_data, i % 3 == 0 ? 32'hA0 : i % 3 == 1 ? 32'hB1 : 32'hC2);
      chk("bad_sel_sticky", 32'(b3.sel_err), 1);
    end
    b3.out_ready = 1'b0;
    b3.in_sel = 2'd0;
    step();
    b3.in_sel = 2'd1;
    step();
    b3.in_sel = 2'd0;
    step();
    chk("flush_pre_two", 32'(b3.in_ready), 0);
    b3.flush = 1'b1;
    b3.in_sel = 2'd2;
    step();
    chk("flush_out_valid", 32'(b3.out_valid), 0);
    chk("flush_in_ready", 32'(b3.in_ready), 1);
    chk("flush_sel_err", 32'(b3.sel_err), 0);
    step();
    chk("flush_drop_accept", 32'(b3.out_valid), 0);
    b3.flush = 1'b0;
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    repeat (2) begin
      step();
      chk("flush_no_ghost", 32'(b3.out_valid), 0);
    end
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd0;
    step();
    b4.in_sel = 2'd3;
    step();
    chk("areset_pre_two", 32'(b4.in_ready), 0);
    b4.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(b4.out_valid), 0);
    chk("areset_in_ready", 32'(b4.in_ready), 1);
    chk("areset_out_data", b4.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd3;
    b4.out_ready = 1'b1;
    step();
    chk("areset_first_accept", b4.out_data, 32'h44);
    chk("areset_first_valid", 32'(b4.out_valid), 1);
    b4.in_valid = 1'b0;
    for (int i = 0; i < 20000 && done < 3; i++) @(posedge clk);
    chk("rnd_done", 32'(done), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
